bkram_sd_ctrl: RTL and testbench

- Moves backup-RAM contents between the save file and the on-chip backup RAM.
- Load reads a fixed run of sectors through the HPS SD sector interface into the RAM second port. Save writes the RAM image back, the write direction the ISO path never uses.
- Also handles format: writes the 4-word HuBM header.
- Sits in emu between hps_io (sd_* signals) and port B of the backup-RAM dual-port RAMs. Holds the core in reset while loading.

---
 rtl/bkram_pkg.sv | 25 ++
 rtl/bkram_sd_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bkram_sd_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bkram_pkg.sv
// Shared definitions for the backup-RAM <-> SD save-file mover:
// FSM state type, HuBM format header words and sector-count default.
package bkram_pkg;

  localparam int SECT_BITS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_FORMAT
  } bk_fsm_e;

  // Header the console expects at the start of a freshly formatted backup RAM.
  localparam logic [15:0] HUBM_HDR [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

  function automatic logic rise(input logic old_v, input logic new_v);
    return new_v & ~old_v;
  endfunction

  function automatic logic fall(input logic old_v, input logic new_v);
    return old_v & ~new_v;
  endfunction

endpackage

// File: rtl/bkram_sd_ctrl.sv
// Moves the backup-RAM image between the HPS save file (sd_* sector port)
// and port B of the backup RAM; also writes the HuBM header on format.
module bkram_sd_ctrl
  import bkram_pkg::*;
#(
  parameter int SECT_BITS = SECT_BITS_DEF,
  parameter int RAM_AW    = SECT_BITS + 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              bk_ena,
  input  logic              bk_load,
  input  logic              bk_save,
  input  logic              dl_end,
  input  logic              img_size_nz,
  input  logic              format,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [7:0]        sd_buff_addr,
  input  logic              sd_buff_wr,
  input  logic [15:0]       sd_buff_dout,
  output logic [15:0]       sd_buff_din,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic              ram_we,
  input  logic [15:0]       ram_q,
  output logic              bk_loading,
  output logic              bk_state,
  output bk_fsm_e           bk_fsm_dbg
);

  // Handshake: sd_rd/sd_wr is a level request held from REQ entry until the
  // HPS raises sd_ack; data words move while sd_ack is high, and the sector
  // is finished when sd_ack falls. Port-B writes happen on cycles with ram_we.

  bk_fsm_e              state_q, state_d;
  logic [SECT_BITS-1:0] lba_q, lba_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 loading_q, loading_d;
  logic                 busy_q, busy_d;
  logic [1:0]           fmt_cnt_q, fmt_cnt_d;

  logic load_old_q, save_old_q, fmt_old_q, ack_old_q;
  logic load_ev, save_ev, fmt_ev, ack_rise, ack_fall;

  assign load_ev  = rise(load_old_q, bk_load);
  assign save_ev  = rise(save_old_q, bk_save);
  assign fmt_ev   = rise(fmt_old_q, format);
  assign ack_rise = rise(ack_old_q, sd_ack);
  assign ack_fall = fall(ack_old_q, sd_ack);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      load_old_q <= 1'b0;
      save_old_q <= 1'b0;
      fmt_old_q  <= 1'b0;
      ack_old_q  <= 1'b0;
    end else begin
      load_old_q <= bk_load;
      save_old_q <= bk_save;
      fmt_old_q  <= format;
      ack_old_q  <= sd_ack;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
      busy_q    <= 1'b0;
      fmt_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      loading_q <= loading_d;
      busy_q    <= busy_d;
      fmt_cnt_q <= fmt_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    busy_d    = busy_q;
    fmt_cnt_d = fmt_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Load takes priority over a save edge arriving in the same cycle.
        if (bk_ena && (load_ev || (dl_end && img_size_nz))) begin
          state_d   = ST_REQ;
          loading_d = 1'b1;
          busy_d    = 1'b1;
          lba_d     = '0;
          rd_d      = 1'b1;
          wr_d      = 1'b0;
        end else if (bk_ena && save_ev) begin
          state_d   = ST_REQ;
          loading_d = 1'b0;
          busy_d    = 1'b1;
          lba_d     = '0;
          rd_d      = 1'b0;
          wr_d      = 1'b1;
        end else if (fmt_ev) begin
          state_d   = ST_FORMAT;
          fmt_cnt_d = 2'd0;
        end
      end

      ST_REQ: begin
        rd_d = loading_q;
        wr_d = ~loading_q;
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        if (ack_fall) begin
          if (&lba_q) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            loading_d = 1'b0;
          end else begin
            state_d = ST_REQ;
            lba_d   = lba_q + SECT_BITS'(1);
            rd_d    = loading_q;
            wr_d    = ~loading_q;
          end
        end
      end

      ST_FORMAT: begin
        fmt_cnt_d = fmt_cnt_q + 2'd1;
        if (fmt_cnt_q == 2'd3) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign sd_lba      = {{(32 - SECT_BITS){1'b0}}, lba_q};
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign sd_buff_din = ram_q;
  assign bk_loading  = loading_q;
  assign bk_state    = busy_q;
  assign bk_fsm_dbg  = state_q;

  // Port B is shared between header writes and the sector stream.
  always_comb begin
    ram_addr = {lba_q, sd_buff_addr};
    ram_din  = sd_buff_dout;
    ram_we   = sd_buff_wr & sd_ack & loading_q;
    if (state_q == ST_FORMAT) begin
      ram_addr = RAM_AW'(fmt_cnt_q);
      ram_din  = HUBM_HDR[fmt_cnt_q];
      ram_we   = 1'b1;
    end
  end

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Directed + randomized bench for bkram_sd_ctrl with an HPS sector model,
// a port-B RAM model and a word-level expected image of the RAM.
module tb_bkram_sd_ctrl;
  import bkram_pkg::*;

  localparam int SB = 4;
  localparam int AW = SB + 8;
  localparam int NW = 1 << AW;
  localparam int NS = 1 << SB;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          bk_ena = 1'b0, bk_load = 1'b0, bk_save = 1'b0;
  logic          dl_end = 1'b0, img_size_nz = 1'b0, format = 1'b0;
  logic [31:0]   sd_lba;
  logic          sd_rd, sd_wr;
  logic          sd_ack = 1'b0;
  logic [7:0]    sd_buff_addr = 8'd0;
  logic          sd_buff_wr = 1'b0;
  logic [15:0]   sd_buff_dout = 16'd0;
  logic [15:0]   sd_buff_din;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic          ram_we;
  logic [15:0]   ram_q;
  logic          bk_loading, bk_state;
  bk_fsm_e       fsm_dbg;

  // clock/reset block
  always #5 clk_sys = ~clk_sys;

  bkram_sd_ctrl #(.SECT_BITS(SB), .RAM_AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .bk_load(bk_load),
    .bk_save(bk_save), .dl_end(dl_end), .img_size_nz(img_size_nz), .format(format),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_q(ram_q), .bk_loading(bk_loading), .bk_state(bk_state), .bk_fsm_dbg(fsm_dbg)
  );

  // Port-B RAM model with a bench-side preload port.
  logic [15:0]   ram [NW];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [15:0]   pre_data = '0;

  always @(posedge clk_sys) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    else if (pre_we) ram[pre_addr] <= pre_data;
    ram_q <= ram[ram_addr];
  end

  // scoreboard
  int          vectors = 0;
  int          errors = 0;
  logic [15:0] exp_mem [NW];
  logic [31:0] exp_q[$];
  logic [15:0] hubm [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (sd_rd || sd_wr) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    chk("req_seen", 32'(got), 32'd1);
  endtask

  // One sector as the HPS performs it: see request, ack, stream 256 words, drop ack.
  task automatic do_sector(input bit is_read, input bit rand_data, output bit ok);
    bit          got;
    logic [31:0] lba;
    logic [11:0] idx;
    logic [15:0] w;
    int          bad, we_seen, first_bad;
    ok = 1'b0;
    wait_req(got);
    if (!got) return;
    lba = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("req_lba", sd_lba, lba);
    chk("req_rd", 32'(sd_rd), 32'(is_read));
    chk("req_wr", 32'(sd_wr), 32'(!is_read));
    chk("req_led", 32'(bk_state), 32'd1);
    chk("req_loading", 32'(bk_loading), 32'(is_read));
    tick($urandom_range(0, 2));
    chk("req_hold", 32'({sd_rd, sd_wr}), is_read ? 32'd2 : 32'd1);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    chk("req_clear", 32'({sd_rd, sd_wr}), 32'd0);
    bad = 0; we_seen = 0; first_bad = -1;
    for (int a = 0; a < 256; a++) begin
      idx = {lba[3:0], 8'(a)};
      sd_buff_addr = 8'(a);
      if (is_read) begin
        w = rand_data ? 16'($urandom) : {lba[7:0], 8'(a)};
        sd_buff_dout = w;
        sd_buff_wr = 1'b1;
        exp_mem[idx] = w;
      end
      @(negedge clk_sys);
      if (!is_read) begin
        if (sd_buff_din !== exp_mem[idx]) begin
          bad++;
          if (first_bad < 0) first_bad = a;
        end
        if (ram_we) we_seen++;
      end
    end
    sd_buff_wr = 1'b0;
    if (!is_read) begin
      chk($sformatf("save_din_lba%0d_first_bad%0d", lba, first_bad), 32'(bad), 32'd0);
      chk("save_no_we", 32'(we_seen), 32'd0);
    end
    tick($urandom_range(0, 2));
    sd_ack = 1'b0;
    @(negedge clk_sys);
    ok = 1'b1;
  endtask

  task automatic xfer_begin();
    exp_q.delete();
    for (int s = 0; s < NS; s++) exp_q.push_back(32'(s));
  endtask

  task automatic xfer_sectors(input bit is_read, input bit rand_data, input int n);
    bit ok;
    for (int s = 0; s < n; s++) begin
      do_sector(is_read, rand_data, ok);
      if (!ok) return;
    end
  endtask

  task automatic xfer_end(input string tag);
    chk({tag, "_end_led"}, 32'(bk_state), 32'd0);
    chk({tag, "_end_loading"}, 32'(bk_loading), 32'd0);
    tick(6);
    chk({tag, "_no_extra_req"}, 32'({sd_rd, sd_wr}), 32'd0);
    chk({tag, "_all_sectors"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic verify_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== exp_mem[i]) bad++;
    chk({tag, "_mem_words_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic preload();
    for (int i = 0; i < NW; i++) begin
      pre_we = 1'b1;
      pre_addr = AW'(i);
      pre_data = 16'($urandom);
      exp_mem[i] = pre_data;
      @(negedge clk_sys);
    end
    pre_we = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    bit got;
    logic [15:0] w;
    hubm[0] = 16'h5548; hubm[1] = 16'h4D42; hubm[2] = 16'h8800; hubm[3] = 16'h8010;
    for (int i = 0; i < NW; i++) exp_mem[i] = 16'd0;

    // Reset values while reset is held.
    tick(3);
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_rd_wr", 32'({sd_rd, sd_wr}), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_loading", 32'(bk_loading), 32'd0);
    chk("rst_led", 32'(bk_state), 32'd0);
    reset = 1'b0;
    tick(2);

    // Load with word = {lba, addr}.
    bk_ena = 1'b1;
    bk_load = 1'b1;
    @(negedge clk_sys);
    chk("load1_loading_start", 32'(bk_loading), 32'd1);
    xfer_begin();
    xfer_sectors(1'b1, 1'b0, NS);
    xfer_end("load1");
    bk_load = 1'b0;
    verify_mem("load1");
    chk("load1_word_3a5", 32'(ram[12'h3A5]), 32'h0000_03A5);

    // Save of a random image.
    preload();
    bk_save = 1'b1;
    @(negedge clk_sys);
    chk("save_led_start", 32'(bk_state), 32'd1);
    chk("save_not_loading", 32'(bk_loading), 32'd0);
    xfer_begin();
    xfer_sectors(1'b0, 1'b0, NS);
    xfer_end("save");
    bk_save = 1'b0;
    verify_mem("save");

    // Auto-load after download, gated by a non-empty image.
    img_size_nz = 1'b0;
    dl_end = 1'b1;
    @(negedge clk_sys);
    dl_end = 1'b0;
    tick(4);
    chk("auto_empty_idle", 32'({bk_state, sd_rd, sd_wr}), 32'd0);
    img_size_nz = 1'b1;
    dl_end = 1'b1;
    @(negedge clk_sys);
    dl_end = 1'b0;
    chk("auto_loading_start", 32'(bk_loading), 32'd1);
    xfer_begin();
    xfer_sectors(1'b1, 1'b1, NS);
    xfer_end("auto");
    verify_mem("auto");

    // Simultaneous load/save edges: load only; a later save edge is dropped.
    bk_load = 1'b1;
    bk_save = 1'b1;
    @(negedge clk_sys);
    chk("both_is_load", 32'(bk_loading), 32'd1);
    xfer_begin();
    xfer_sectors(1'b1, 1'b1, 2);
    bk_save = 1'b0;
    @(negedge clk_sys);
    bk_save = 1'b1;
    xfer_sectors(1'b1, 1'b1, NS - 2);
    xfer_end("both");
    bk_load = 1'b0;
    bk_save = 1'b0;
    verify_mem("both");

    // Format header.
    format = 1'b1;
    @(negedge clk_sys);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fmt_we%0d", k), 32'(ram_we), 32'd1);
      chk($sformatf("fmt_addr%0d", k), 32'(ram_addr), 32'(k));
      chk($sformatf("fmt_data%0d", k), 32'(ram_din), 32'(hubm[k]));
      chk($sformatf("fmt_quiet%0d", k), 32'({sd_rd, sd_wr, bk_state}), 32'd0);
      exp_mem[k] = hubm[k];
      @(negedge clk_sys);
    end
    chk("fmt_done_we", 32'(ram_we), 32'd0);
    format = 1'b0;
    tick(2);
    verify_mem("fmt");

    // Reset in the middle of sector 7 of a load.
    bk_load = 1'b1;
    @(negedge clk_sys);
    xfer_begin();
    xfer_sectors(1'b1, 1'b1, 7);
    wait_req(got);
    chk("mid_lba7", sd_lba, 32'd7);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    for (int a = 0; a < 20; a++) begin
      w = 16'($urandom);
      sd_buff_addr = 8'(a);
      sd_buff_dout = w;
      sd_buff_wr = 1'b1;
      exp_mem[{4'd7, 8'(a)}] = w;
      @(negedge clk_sys);
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_rd", 32'(sd_rd), 32'd0);
    chk("mid_rst_loading", 32'(bk_loading), 32'd0);
    chk("mid_rst_led", 32'(bk_state), 32'd0);
    chk("mid_rst_we", 32'(ram_we), 32'd0);
    chk("mid_rst_lba", sd_lba, 32'd0);
    bk_load = 1'b0;
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    tick(2);
    sd_ack = 1'b0;
    tick(4);
    chk("mid_ack_ignored", 32'({bk_state, sd_rd, sd_wr}), 32'd0);
    verify_mem("mid");
    bk_load = 1'b1;
    @(negedge clk_sys);
    chk("reload_loading", 32'(bk_loading), 32'd1);
    xfer_begin();
    xfer_sectors(1'b1, 1'b1, NS);
    xfer_end("reload");
    bk_load = 1'b0;
    verify_mem("reload");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
